// File: rtl/sw_wait_ctrl_pkg.sv
// sw_wait_ctrl_pkg: shared constants and types for the switch wait controller
package sw_wait_ctrl_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DEBOUNCE_CYCLES = 16;
    typedef enum logic {IDLE, ARMED} wait_state_t;
    typedef enum logic {PRESS, RELEASE} wait_mode_t;
endpackage

// File: rtl/sw_wait_ctrl_if.sv
// sw_wait_ctrl_if: board pins, decoder requests and pcnt/register-file outputs
interface sw_wait_ctrl_if #(
    parameter int DATA_WIDTH = sw_wait_ctrl_pkg::DATA_WIDTH
);
    logic                  key_raw;
    logic [DATA_WIDTH-1:0] sw_raw;
    logic                  wait_press;
    logic                  wait_release;
    logic                  pc_stall;
    logic [DATA_WIDTH-1:0] sw_data;
    logic                  data_valid;
    logic                  key_level;
    modport master (
        output key_raw, sw_raw, wait_press, wait_release,
        input  pc_stall, sw_data, data_valid, key_level
    );
    modport slave (
        input  key_raw, sw_raw, wait_press, wait_release,
        output pc_stall, sw_data, data_valid, key_level
    );
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: synchronises the handshake key and accepts a level change only after it is stable
module sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic Rst,
    input  logic i_key_raw,
    output logic o_key_level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    // shift the key through the synchroniser and count cycles it disagrees with the accepted level
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_raw};
            if (r_sync[SYNC_STAGES-1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign o_key_level = r_level;
endmodule

// File: rtl/sw_wait_ctrl.sv
// sw_wait_ctrl: stalls pcnt on wait instructions until the matching debounced key edge, capturing switches on press
module sw_wait_ctrl
    import sw_wait_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = sw_wait_ctrl_pkg::DATA_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = sw_wait_ctrl_pkg::DEBOUNCE_CYCLES
) (
    input logic           clk,
    input logic           Rst,
    sw_wait_ctrl_if.slave bus
);
    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_ARMED = ARMED;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sw_pipe;
    logic [DATA_WIDTH-1:0]                  r_sw_data;
    logic                                   r_valid;
    logic                                   r_key_level_q;
    logic [0:0]                             r_state;
    wait_mode_t                             r_mode;
    wait_mode_t                             w_mode;
    logic                                   w_key_level;
    logic                                   w_rise;
    logic                                   w_fall;
    logic                                   w_req;
    logic                                   w_hit;
    logic                                   w_capture;

    sw_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .Rst        (Rst),
        .i_key_raw  (bus.key_raw),
        .o_key_level(w_key_level)
    );

    // edge pulses and request decode; once armed the latched mode decides which edge completes the wait
    always_comb begin
        w_rise    = w_key_level & ~r_key_level_q;
        w_fall    = ~w_key_level & r_key_level_q;
        w_req     = bus.wait_press | bus.wait_release;
        w_mode    = (r_state == S_ARMED) ? r_mode : (bus.wait_press ? PRESS : RELEASE);
        w_hit     = (w_mode == PRESS) ? w_rise : w_fall;
        w_capture = w_req & w_hit & (w_mode == PRESS);
    end

    assign bus.pc_stall   = ~Rst & w_req & ~w_hit;
    assign bus.sw_data    = r_sw_data;
    assign bus.data_valid = r_valid;
    assign bus.key_level  = w_key_level;

    // synchronise the switches, delay key_level for edge detection and capture on a press hit
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_sw_pipe     <= '0;
            r_sw_data     <= '0;
            r_valid       <= 1'b0;
            r_key_level_q <= 1'b0;
        end else begin
            r_sw_pipe     <= {r_sw_pipe[SYNC_STAGES-2:0], bus.sw_raw};
            r_key_level_q <= w_key_level;
            r_valid       <= w_capture;
            if (w_capture) r_sw_data <= r_sw_pipe[SYNC_STAGES-1];
        end
    end

    // arm on an unsatisfied request, disarm on the matching edge or when the request is withdrawn
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_mode  <= PRESS;
        end else if (r_state == S_IDLE && w_req && !w_hit) begin
            r_state <= S_ARMED;
            r_mode  <= w_mode;
        end else if (r_state == S_ARMED && (w_hit || !w_req)) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_sw_wait_ctrl.sv
// tb_sw_wait_ctrl: directed and random stimulus checked every cycle against a behavioural model
module tb_sw_wait_ctrl;
    import sw_wait_ctrl_pkg::*;
    localparam int S = 2;
    localparam int D = DEBOUNCE_CYCLES;
    localparam int W = DATA_WIDTH;
    logic clk = 1'b0;
    logic Rst = 1'b1;
    logic cmp_en = 1'b0;
    int total = 0;
    int bad = 0;

    sw_wait_ctrl_if #(.DATA_WIDTH(W)) bus ();
    sw_wait_ctrl #(.DATA_WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic ks[$];
    logic [W-1:0] ss[$];
    logic win[$];
    logic m_level, m_level_q, m_armed, m_mpress, m_valid;
    logic [W-1:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_hit();
        logic mp;
        mp = m_armed ? m_mpress : bus.wait_press;
        return mp ? (m_level && !m_level_q) : (!m_level && m_level_q);
    endfunction

    always @(posedge clk) begin
        if (Rst) begin
            ks = {};
            ss = {};
            win = {};
            for (int i = 0; i < S; i++) begin
                ks.push_back(1'b0);
                ss.push_back('0);
            end
            m_level = 0; m_level_q = 0; m_armed = 0; m_mpress = 0; m_valid = 0; m_data = '0;
        end else begin
            logic req, hit, mp, all_diff;
            req = bus.wait_press || bus.wait_release;
            mp = m_armed ? m_mpress : bus.wait_press;
            hit = m_hit();
            m_valid = req && hit && mp;
            if (m_valid) m_data = ss[S-1];
            if (!m_armed && req && !hit) begin
                m_armed = 1;
                m_mpress = bus.wait_press;
            end else if (m_armed && (hit || !req)) begin
                m_armed = 0;
            end
            m_level_q = m_level;
            win.push_back(ks[S-1]);
            if (win.size() > D) void'(win.pop_front());
            all_diff = (win.size() == D);
            foreach (win[i]) if (win[i] == m_level) all_diff = 0;
            if (all_diff) m_level = !m_level;
            ks.push_front(bus.key_raw);
            void'(ks.pop_back());
            ss.push_front(bus.sw_raw);
            void'(ss.pop_back());
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic exp_stall;
            exp_stall = !Rst && (bus.wait_press || bus.wait_release) && !m_hit();
            chk("pc_stall", bus.pc_stall, exp_stall);
            chk("sw_data", bus.sw_data, m_data);
            chk("data_valid", bus.data_valid, m_valid);
            chk("key_level", bus.key_level, m_level);
        end
    end

    initial begin
        int n, r, hold, rhold;
        logic seen;
        bus.key_raw = 1; bus.sw_raw = 8'hA5; bus.wait_press = 1; bus.wait_release = 0;
        tick();
        cmp_en = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_stall", bus.pc_stall, 0);
            chk("rst_data", bus.sw_data, 0);
            chk("rst_valid", bus.data_valid, 0);
            chk("rst_level", bus.key_level, 0);
            tick();
        end
        Rst = 0;
        n = 0;
        do begin tick(); n++; end while (!bus.key_level && n < 100);
        chk("rst_release_latency", n, 18);
        tick();
        chk("first_capture", bus.sw_data, 8'hA5);
        bus.wait_press = 0; bus.key_raw = 0;
        repeat (30) tick();
        bus.key_raw = 1; seen = 0;
        repeat (10) begin tick(); seen |= bus.key_level; end
        bus.key_raw = 0;
        repeat (30) begin tick(); seen |= bus.key_level; end
        chk("glitch10_no_level", seen, 0);
        bus.key_raw = 1; n = 0;
        do begin tick(); n++; end while (!bus.key_level && n < 100);
        chk("pulse20_latency", n, 18);
        repeat (2) tick();
        bus.key_raw = 0;
        repeat (30) tick();
        chk("pulse20_released", bus.key_level, 0);
        bus.sw_raw = 8'h3C; bus.wait_press = 1; bus.key_raw = 1; n = 0;
        do begin tick(); n++; end while (bus.pc_stall && n < 100);
        chk("press_stall_cycles", n, 18);
        chk("press_valid_before", bus.data_valid, 0);
        tick();
        chk("press_data", bus.sw_data, 8'h3C);
        chk("press_valid", bus.data_valid, 1);
        bus.wait_press = 0;
        tick();
        chk("press_valid_once", bus.data_valid, 0);
        bus.sw_raw = 8'h5A; bus.wait_press = 1;
        repeat (30) tick();
        chk("held_key_stall", bus.pc_stall, 1);
        bus.key_raw = 0; seen = 0;
        repeat (40) begin tick(); seen |= bus.data_valid; end
        chk("release_no_capture", seen, 0);
        chk("release_still_stall", bus.pc_stall, 1);
        bus.key_raw = 1; n = 0;
        do begin tick(); n++; end while (bus.pc_stall && n < 100);
        chk("repress_stall_cycles", n, 18);
        tick();
        chk("repress_data", bus.sw_data, 8'h5A);
        bus.wait_press = 0; bus.sw_raw = 8'h99; bus.wait_release = 1;
        repeat (5) tick();
        chk("wait_release_stall", bus.pc_stall, 1);
        bus.key_raw = 0; n = 0;
        do begin tick(); n++; end while (bus.pc_stall && n < 100);
        chk("release_stall_cycles", n, 18);
        tick();
        chk("release_data_kept", bus.sw_data, 8'h5A);
        chk("release_no_valid", bus.data_valid, 0);
        bus.wait_release = 0; bus.wait_press = 1;
        repeat (5) tick();
        chk("armed_stall", bus.pc_stall, 1);
        Rst = 1;
        @(negedge clk);
        chk("rst_mid_wait_stall", bus.pc_stall, 0);
        tick();
        Rst = 0;
        repeat (3) tick();
        chk("rearm_stall", bus.pc_stall, 1);
        bus.key_raw = 1; n = 0;
        do begin tick(); n++; end while (bus.pc_stall && n < 100);
        chk("rearm_stall_cycles", n, 18);
        tick();
        chk("rearm_data", bus.sw_data, 8'h99);
        bus.wait_press = 0; bus.key_raw = 0;
        repeat (30) tick();
        hold = 0; rhold = 0;
        repeat (4000) begin
            if (hold == 0) begin
                bus.key_raw = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 40);
            end
            hold--;
            if (rhold == 0) begin
                r = $urandom_range(0, 3);
                bus.wait_press = r[0];
                bus.wait_release = r[1];
                rhold = $urandom_range(1, 60);
            end
            rhold--;
            bus.sw_raw = W'($urandom);
            Rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        Rst = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
